// File: rtl/dsp_pkg.sv
// Shared DSP definitions: default sample width, signed sample type and
// the accumulator width helper used by the decimator.
package dsp_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

  // Width needed to sum 2^decim_log2 samples without overflow
  function automatic int acc_width(input int data_width, input int decim_log2);
    return data_width + decim_log2;
  endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// Sample-in / result-out handshake bundle of the decimator.
// slave = decimator side, master = producer/consumer side.
interface fir_decimator_if
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/dsp_sync_fifo.sv
// Synchronous FIFO with occupancy count. A push on a full FIFO is only
// accepted when a pop happens in the same cycle; the read word is shown
// combinationally and forced to zero while empty.
module dsp_sync_fifo
  import dsp_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign wr_en    = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since reads are masked while empty
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator by 2^DECIM_LOG2 with a result FIFO behind
// a valid/ready output and a sticky flag for dropped results.
// Build option: define DECIM_ROUND_EN to round half toward +inf instead
// of flooring the window average.
module fir_decimator
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  fir_decimator_if.slave                    bus,
  input  logic                              sync,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              ovf_sticky,
  input  logic                              ovf_clr
);

  localparam int ACC_W = acc_width(DATA_WIDTH, DECIM_LOG2);
  localparam int M     = 1 << DECIM_LOG2;
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);
`ifdef DECIM_ROUND_EN
  // M/2 is zero for M = 1, so rounding is a no-op without decimation
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(M / 2);
`endif

  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      acc_base;
  logic signed [ACC_W-1:0]      sum;
  logic signed [ACC_W-1:0]      sum_adj;
  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             cnt_base;
  logic signed [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0]        fifo_dout;
  logic                         window_done;
  logic                         pop;
  logic                         full;
  logic                         empty;
  logic                         drop;

  // Window arithmetic; sync makes this cycle's sample the first of a new window
  always_comb begin
    acc_base    = sync ? '0 : acc;
    cnt_base    = sync ? '0 : cnt;
    sum         = acc_base + ACC_W'(bus.in_data);
`ifdef DECIM_ROUND_EN
    sum_adj     = sum + ROUND_BIAS;
`else
    sum_adj     = sum;
`endif
    result      = DATA_WIDTH'(sum_adj >>> DECIM_LOG2);
    window_done = bus.in_valid && (cnt_base == CNT_LAST);
  end

  // Accumulator and sample counter; cleared on dump, sync or reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.in_valid) begin
      if (window_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt_base + CNT_W'(1);
      end
    end else if (sync) begin
      acc <= '0;
      cnt <= '0;
    end
  end

  assign pop  = !empty && bus.out_ready;
  assign drop = window_done && full && !pop;

  // Drop indication; a drop in the same cycle overrides a clear request
  always_ff @(posedge clk) begin
    if (!rst_n)       ovf_sticky <= 1'b0;
    else if (drop)    ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end

  dsp_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (window_done),
    .push_data (result),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = fifo_dout;

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator (DECIM_LOG2=2, FIFO_DEPTH=4): directed scenarios
// followed by random traffic, all compared against a queue-based model.
module tb_fir_decimator;
  import dsp_pkg::*;

  localparam int DL2   = 2;
  localparam int M     = 1 << DL2;
  localparam int DEPTH = 4;
`ifdef DECIM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sync;
  logic       ovf_clr;
  logic       ovf_sticky;
  logic [2:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  int win[$];
  int exp_q[$];
  bit exp_ovf;

  fir_decimator_if #(.DATA_WIDTH(16)) bus ();

  fir_decimator #(
    .DATA_WIDTH (16),
    .DECIM_LOG2 (DL2),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sync       (sync),
    .fifo_level (fifo_level),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int floor_div(input int s, input int m);
    int q;
    q = s / m;
    if ((s % m) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // Window average from plain arithmetic on the collected samples
  function automatic int window_result();
    int s;
    s = 0;
    foreach (win[i]) s += win[i];
    if (RND) return floor_div(s + M / 2, M);
    return floor_div(s, M);
  endfunction

  function automatic int rnd_sample();
    sample_t s;
    s = 16'($urandom);
    return int'(s);
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
    check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    check("ovf_sticky", 32'(ovf_sticky), 32'(exp_ovf));
    if (exp_q.size() > 0) check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
  endtask

  task automatic step(input bit v, input int d, input bit s, input bit rdy, input bit clr);
    bit pop;
    bit push;
    int r;
    bus.in_valid  = v;
    bus.in_data   = 16'(d);
    sync          = s;
    bus.out_ready = rdy;
    ovf_clr       = clr;
    pop  = rdy && (exp_q.size() > 0);
    push = 1'b0;
    r    = 0;
    if (s) win.delete();
    if (v) begin
      win.push_back(d);
      if (win.size() == M) begin
        r = window_result();
        win.delete();
        push = 1'b1;
      end
    end
    if (push && exp_q.size() == DEPTH && !pop) begin
      exp_ovf = 1'b1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(r);
      if (clr) exp_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'd7;
    sync          = 1'b0;
    bus.out_ready = 1'b0;
    ovf_clr       = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    win.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    sync          = 1'b0;
    ovf_clr       = 1'b0;
    exp_ovf       = 1'b0;
    do_reset();
    step(0, 0, 0, 0, 0);

    // 1,2,3,4 -> 2 (3 with rounding), visible right after the fourth sample
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    check("latency_pre", 32'(bus.out_valid), 32'd0);
    step(1, 4, 0, 0, 0);
    check("avg_1234_valid", 32'(bus.out_valid), 32'd1);
    check("avg_1234", 32'(bus.out_data), RND ? 32'd3 : 32'd2);
    step(0, 0, 0, 1, 0);

    // negative floor/round and full-scale windows
    step(1, -1, 0, 1, 0);
    step(1, -1, 0, 1, 0);
    step(1, -1, 0, 1, 0);
    step(1, -2, 0, 1, 0);
    check("avg_neg", 32'(bus.out_data), RND ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
    for (int k = 0; k < M; k++) step(1, 32767, 0, 1, 0);
    check("avg_max", 32'(bus.out_data), 32'd32767);
    for (int k = 0; k < M; k++) step(1, -32768, 0, 1, 0);
    check("avg_min", 32'(bus.out_data), 32'hFFFF_8000);
    step(0, 0, 0, 1, 0);

    // back-pressure: five windows into four entries
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < M; k++) step(1, rnd_sample(), 0, 0, 0);
    check("full_level", 32'(fifo_level), 32'd4);
    check("ovf_set", 32'(ovf_sticky), 32'd1);
    for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 1, 0);
    check("drained_level", 32'(fifo_level), 32'd0);
    step(0, 0, 0, 0, 1);
    check("ovf_cleared", 32'(ovf_sticky), 32'd0);

    // clear coincident with a drop keeps the flag
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < M; k++) step(1, rnd_sample(), 0, 0, 0);
    for (int k = 0; k < M - 1; k++) step(1, rnd_sample(), 0, 0, 0);
    step(1, rnd_sample(), 0, 0, 1);
    check("clr_vs_drop", 32'(ovf_sticky), 32'd1);
    step(0, 0, 0, 0, 1);
    check("ovf_cleared2", 32'(ovf_sticky), 32'd0);

    // full FIFO, pop in the completing cycle -> no drop
    for (int k = 0; k < M - 1; k++) step(1, rnd_sample(), 0, 0, 0);
    step(1, rnd_sample(), 0, 1, 0);
    check("push_pop_full_level", 32'(fifo_level), 32'd4);
    check("push_pop_full_ovf", 32'(ovf_sticky), 32'd0);
    for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 1, 0);

    // sync discards a partial window
    step(1, 100, 0, 1, 0);
    step(1, 100, 0, 1, 0);
    step(1, 8, 1, 1, 0);
    step(1, 8, 0, 1, 0);
    step(1, 8, 0, 1, 0);
    check("sync_pre", 32'(bus.out_valid), 32'd0);
    step(1, 8, 0, 1, 0);
    check("sync_result", 32'(bus.out_data), 32'd8);
    step(0, 0, 0, 1, 0);
    check("sync_single", 32'(fifo_level), 32'd0);

    // reset mid-window discards the partial sum
    step(1, 1000, 0, 0, 0);
    step(1, 1000, 0, 0, 0);
    step(1, 1000, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < M; k++) step(1, 4, 0, 0, 0);
    check("post_rst_result", 32'(bus.out_data), 32'd4);
    check("post_rst_level", 32'(fifo_level), 32'd1);
    step(0, 0, 0, 1, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, rnd_sample(), $urandom_range(0, 24) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the FIR filter: consumes the filtered sample stream, decimates by 2^DECIM_LOG2 using integrate-and-dump averaging, and buffers the decimated results in a small FIFO behind a valid/ready output. Absorbs back-pressure from the consumer and flags any result dropped because the FIFO was full.

## Interface
- DATA_WIDTH, 16: width of input and output samples (signed two's complement)
- DECIM_LOG2, 2: log2 of the decimation factor M; legal range 0..6
- FIFO_DEPTH, 4: output buffer entries; power of two, ≥ 2
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  in_data carries a FIR output sample this cycle
- in_data  in  DATA_WIDTH  signed FIR output sample
- sync  in  1  restart the decimation window (phase alignment)
- out_valid  out  1  out_data holds a decimated result
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  DATA_WIDTH  signed decimated result
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
- ovf_sticky  out  1  at least one result dropped since last clear
- ovf_clr  in  1  clear ovf_sticky

## Operation
- Accumulator acc is signed, DATA_WIDTH+DECIM_LOG2 bits; sample counter cnt runs 0..M-1.
- in_valid with cnt < M-1: acc <= acc + in_data (sign-extended); cnt <= cnt+1.
- in_valid with cnt == M-1: sum = acc + in_data; result = sum >>> DECIM_LOG2 (arithmetic); push result into FIFO; acc <= 0; cnt <= 0.
- DECIM_LOG2 = 0: every valid sample is pushed unchanged.
- Result always fits DATA_WIDTH; no saturation logic.
- sync: discard the partial window (acc, cnt cleared). With in_valid in the same cycle, in_data is the first sample of the new window (pushed directly when M = 1).
- FIFO push on a full FIFO with no pop in the same cycle: result dropped, ovf_sticky <= 1, FIFO contents unchanged.
- Full FIFO with pop and push in the same cycle: both take effect, no drop.
- Pop on out_valid && out_ready; results leave in arrival order.
- ovf_clr clears ovf_sticky; a drop in the same cycle wins (flag stays 1).
- Reset values: out_valid 0, out_data 0, fifo_level 0, ovf_sticky 0, acc 0, cnt 0, FIFO empty. Reset mid-window discards the partial sum and all buffered results.

## Timing
- Latency: final window sample sampled at edge n → out_valid = 1 and out_data valid after edge n (one cycle), provided the FIFO was empty.
- in_valid may be asserted every cycle; the block never stalls its input.
- out_data and out_valid are stable while out_valid && !out_ready.
- fifo_level updates on the same edge as the push or pop.

## Configuration
- DECIM_ROUND_EN defined: add 2^(DECIM_LOG2-1) to sum before the shift (round half toward +inf); no effect when DECIM_LOG2 = 0. Overflow is impossible: max·M + M/2 < (max+1)·M.
- DECIM_ROUND_EN undefined: plain arithmetic shift (floor).

## Structure
- Shared package dsp_pkg: default DATA_WIDTH constant, the signed sample typedef, and a localparam function for accumulator width (DATA_WIDTH+DECIM_LOG2).
- One sub-module: dsp_sync_fifo (parameterised width/depth, push/pop/full/empty/level, simultaneous push+pop when full). The decimator core instantiates it.

## Test plan
- DECIM_LOG2=2, continuous in_valid, samples 1,2,3,4 → out_data 2 (ROUND_EN: 3), out_valid one cycle after sample 4.
- Samples -1,-1,-1,-2 → sum -5 → out_data -2 (ROUND_EN: -1); samples 32767×4 → 32767 in both builds.
- out_ready=0, five full windows → fifo_level 4, fifth dropped, ovf_sticky=1; then out_ready=1 → four results in order; ovf_clr → 0; ovf_clr coincident with a drop → stays 1.
- Two samples of 100, then sync with in_valid and in_data 8, then 8,8,8 → single output 8; the 100s never appear.
- FIFO full, out_ready=1 in the cycle a window completes → no drop, fifo_level stays 4, ovf_sticky stays 0.
- Three samples accumulated, rst_n low one cycle, then 4,4,4,4 → single output 4; all outputs read reset values during and after reset.
